// File: rtl/bcd_conv_arbiter.sv
// Shared double-dabble binary-to-BCD engine with an arbiter in front of N_REQ requesters.
// Optional macro BCD_ARB_FIXED_PRIO_EN: lowest-index fixed priority instead of round-robin.

module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din > 4'd4) ? din + 4'd3 : din;
endmodule

module bcd_conv_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_bin,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [11:0]          rsp_bcd,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 busy
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]      state;
    logic [19:0]     work;
    logic [19:0]     adj;
    logic [2:0]      cnt;
    logic [ID_W-1:0] id;
    logic [ID_W-1:0] winner;
    logic [7:0]      win_bin;
    logic            found;
    logic            accept;
    logic            unused_msb;

    // Add-3 correction on the three BCD digit columns before each shift.
    assign adj[7:0] = work[7:0];
    for (genvar g = 0; g < 3; g++) begin : g_dig
        bcd_digit_adj u_adj (
            .din  (work[8+4*g +: 4]),
            .dout (adj[8+4*g +: 4])
        );
    end
    // The top bit never gets set for an 8-bit operand; the shift drops it.
    assign unused_msb = adj[19];

`ifdef BCD_ARB_FIXED_PRIO_EN
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        win_bin = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                found   = 1'b1;
                winner  = ID_W'(i);
                win_bin = req_bin[8*i +: 8];
            end
        end
    end
`else
    logic [ID_W-1:0] last_grant;
    int              rr_idx;

    // Scan farthest-first so the requester nearest after last_grant overwrites.
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        win_bin = '0;
        rr_idx  = 0;
        for (int i = N_REQ; i >= 1; i--) begin
            rr_idx = (int'(last_grant) + i) % N_REQ;
            if (req_valid[rr_idx]) begin
                found   = 1'b1;
                winner  = ID_W'(rr_idx);
                win_bin = req_bin[8*rr_idx +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= ID_W'(N_REQ - 1);
        else if (accept)
            last_grant <= winner;
    end
`endif

    assign accept    = (state == S_IDLE) && found && !rst;
    assign req_ready = accept ? ({{(N_REQ-1){1'b0}}, 1'b1} << winner) : '0;
    assign rsp_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            work    <= '0;
            cnt     <= '0;
            id      <= '0;
            rsp_bcd <= '0;
            rsp_id  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        work  <= {12'd0, win_bin};
                        id    <= winner;
                        cnt   <= '0;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    work <= {adj[18:0], 1'b0};
                    cnt  <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        rsp_bcd <= adj[18:7];
                        rsp_id  <= id;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (rsp_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter: latency, result values, arbitration order, stall and reset.
module tb_bcd_conv_arbiter;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [8*N-1:0] req_bin;
    logic [N-1:0]  req_ready;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [11:0]   rsp_bcd;
    logic [1:0]    rsp_id;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc_cnt = 0;

    bcd_conv_arbiter #(.N_REQ(N), .ID_W(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_bin(req_bin),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_bcd(rsp_bcd), .rsp_id(rsp_id), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // Drives one request and measures; callers do the comparisons.
    task automatic run_one(input int k, input logic [7:0] v, output logic [N-1:0] rr,
                           output int lat, output logic b1, output logic b10,
                           output logic [11:0] bcd, output logic [1:0] id);
        req_bin[8*k +: 8] = v;
        req_valid[k] = 1'b1;
        #1 rr = req_ready;
        @(negedge clk); #1;
        req_valid[k] = 1'b0;
        b1 = busy;
        lat = 1;
        while (!rsp_valid && lat < 30) begin
            @(negedge clk); #1;
            lat++;
        end
        bcd = rsp_bcd;
        id  = rsp_id;
        @(negedge clk); #1;
        b10 = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '1; rsp_ready = 1'b1; req_bin = '0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_cmp++; if (rsp_bcd !== 12'h000) begin n_err++; $display("FAIL reset_rsp_bcd got %h exp 000", rsp_bcd); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id got %0d exp 0", rsp_id); end
        rst = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL reset_first_grant got %b exp 0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_single();
        logic [N-1:0] rr; int lat; logic b1, b10; logic [11:0] bcd; logic [1:0] id;
        do_reset();
        run_one(0, 8'd255, rr, lat, b1, b10, bcd, id);
        n_cmp++; if (rr !== 4'b0001) begin n_err++; $display("FAIL single_ready got %b exp 0001", rr); end
        n_cmp++; if (b1 !== 1'b1) begin n_err++; $display("FAIL single_busy_t1 got %b exp 1", b1); end
        n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL single_latency got %0d exp 9", lat); end
        n_cmp++; if (bcd !== 12'h255) begin n_err++; $display("FAIL single_bcd got %h exp 255", bcd); end
        n_cmp++; if (id !== 2'd0) begin n_err++; $display("FAIL single_id got %0d exp 0", id); end
        n_cmp++; if (b10 !== 1'b0) begin n_err++; $display("FAIL single_busy_t10 got %b exp 0", b10); end
    endtask

    task automatic test_sweep();
        logic [N-1:0] rr; int lat; logic b1, b10; logic [11:0] bcd, exp; logic [1:0] id;
        do_reset();
        for (int v = 0; v < 256; v++) begin
            exp = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            run_one(1, 8'(v), rr, lat, b1, b10, bcd, id);
            n_cmp++; if (bcd !== exp || id !== 2'd1 || lat !== 9) begin
                n_err++; $display("FAIL sweep v=%0d got bcd=%h id=%0d lat=%0d exp bcd=%h id=1 lat=9", v, bcd, id, lat, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ops [4];
        logic [11:0] exps [4];
        int order [6];
        int w, last_t, ngr;
        logic [3:0] expv;
        ops  = '{8'd7, 8'd58, 8'd199, 8'd230};
        exps = '{12'h007, 12'h058, 12'h199, 12'h230};
`ifdef BCD_ARB_FIXED_PRIO_EN
        order = '{0, 0, 0, 0, 1, 1};
`else
        order = '{0, 1, 2, 3, 0, 1};
`endif
        do_reset();
        for (int k = 0; k < 4; k++) req_bin[8*k +: 8] = ops[k];
        req_valid = 4'hF;
        #1;
        last_t = 0;
        for (int g = 0; g < 6; g++) begin
            w = 0;
            while (req_ready == 4'b0000 && w < 40) begin @(negedge clk); #1; w++; end
            expv = 4'b0001 << order[g];
            n_cmp++; if (req_ready !== expv) begin n_err++; $display("FAIL rr_grant%0d got %b exp %b", g, req_ready, expv); end
            if (g > 0 && g != 4) begin
                n_cmp++; if (cyc_cnt - last_t !== 10) begin n_err++; $display("FAIL rr_interval%0d got %0d exp 10", g, cyc_cnt - last_t); end
            end
            last_t = cyc_cnt;
            w = 0;
            do begin @(negedge clk); #1; w++; end while (!rsp_valid && w < 40);
            n_cmp++; if (rsp_id !== 2'(order[g]) || rsp_bcd !== exps[order[g]]) begin
                n_err++; $display("FAIL rr_rsp%0d got id=%0d bcd=%h exp id=%0d bcd=%h", g, rsp_id, rsp_bcd, order[g], exps[order[g]]);
            end
`ifdef BCD_ARB_FIXED_PRIO_EN
            if (g == 3) req_valid[0] = 1'b0;
`endif
        end
        req_valid = '0;
    endtask

    task automatic test_stall();
        logic [11:0] hb; logic [1:0] hid; int w, bad;
        do_reset();
        rsp_ready = 1'b0;
        req_bin[8*2 +: 8] = 8'd173;
        req_valid[2] = 1'b1;
        @(negedge clk); #1;
        req_valid[2] = 1'b0;
        w = 0;
        while (!rsp_valid && w < 30) begin @(negedge clk); #1; w++; end
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL stall_rsp_valid got %b exp 1", rsp_valid); end
        hb = rsp_bcd; hid = rsp_id;
        n_cmp++; if (hb !== 12'h173 || hid !== 2'd2) begin n_err++; $display("FAIL stall_result got bcd=%h id=%0d exp bcd=173 id=2", hb, hid); end
        req_bin[8*3 +: 8] = 8'd1;
        req_valid[3] = 1'b1;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_bcd !== 12'h173 || rsp_id !== 2'd2 || req_ready !== 4'b0000) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL stall_hold got %0d bad cycles exp 0", bad); end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL stall_release got valid=%b busy=%b exp 0 0", rsp_valid, busy); end
        n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL stall_next_grant got %b exp 1000", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_mid_reset();
        logic [N-1:0] rr; int lat, pulses; logic b1, b10; logic [11:0] bcd; logic [1:0] id;
        do_reset();
        req_bin[7:0] = 8'd200;
        req_valid[0] = 1'b1;
        @(negedge clk); #1;
        req_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy_before got %b exp 1", busy); end
        rst = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL midrst_idle got busy=%b valid=%b exp 0 0", busy, rsp_valid); end
        rst = 1'b0;
        pulses = 0;
        repeat (12) begin @(negedge clk); #1; if (rsp_valid) pulses++; end
        n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL midrst_no_rsp got %0d pulses exp 0", pulses); end
        run_one(0, 8'd42, rr, lat, b1, b10, bcd, id);
        n_cmp++; if (bcd !== 12'h042 || id !== 2'd0 || lat !== 9) begin
            n_err++; $display("FAIL midrst_rerun got bcd=%h id=%0d lat=%0d exp bcd=042 id=0 lat=9", bcd, id, lat);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_bin = '0; rsp_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_sweep();
        test_back_to_back();
        test_stall();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
